// File: rtl/flit_packetizer.sv
// Wormhole packet injector: turns a (dst, len) descriptor plus payload words into HEADER/PAYLOAD/TAIL flits.
// Optional FLIT_CHECKSUM_EN: every payload word goes out as PAYLOAD, followed by a TAIL carrying an XOR checksum.
module flit_packetizer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cur_addr,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [3:0]        pkt_dst,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic              empty,
  output logic [2:0]        flit_id,
  output logic [3:0]        dst_addr,
  output logic [DATA_W-1:0] flit_data,
  output logic              busy
);

  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_ZTAIL, S_CSUM} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              empty_q;
  logic              busy_q;
  logic [2:0]        id_q;
  logic [3:0]        dst_q;
  logic [DATA_W-1:0] data_q;

  logic              slot_free;
  logic              pkt_acc;
  logic              din_acc;
  logic              last_word;
  logic [DATA_W-1:0] hdr_data;
  logic [DATA_W-1:0] tail_data;

`ifdef FLIT_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  assign tail_data = csum_q;
`else
  assign tail_data = '0;
`endif

  // The output register can take a new flit when it is empty or being popped this cycle.
  assign slot_free = empty_q | rd;
  assign pkt_ready = rst & (state_q == S_IDLE) & slot_free;
  assign din_ready = rst & (state_q == S_BODY) & slot_free;
  assign pkt_acc   = pkt_valid & pkt_ready;
  assign din_acc   = din_valid & din_ready;
  assign last_word = (cnt_q == LEN_W'(1));
  assign hdr_data  = DATA_W'({pkt_len, cur_addr, pkt_dst});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      busy_q  <= 1'b0;
      id_q    <= '0;
      dst_q   <= '0;
      data_q  <= '0;
`ifdef FLIT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      // A pop empties the slot unless a new flit is loaded on the same edge below.
      if (rd) empty_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pkt_acc) begin
            cnt_q   <= pkt_len;
            empty_q <= 1'b0;
            busy_q  <= 1'b1;
            id_q    <= FLIT_HEADER;
            dst_q   <= pkt_dst;
            data_q  <= hdr_data;
`ifdef FLIT_CHECKSUM_EN
            csum_q  <= hdr_data;
            state_q <= (pkt_len != '0) ? S_BODY : S_CSUM;
`else
            state_q <= (pkt_len != '0) ? S_BODY : S_ZTAIL;
`endif
          end
        end
        S_BODY: begin
          if (din_acc) begin
            cnt_q   <= cnt_q - LEN_W'(1);
            empty_q <= 1'b0;
            data_q  <= din;
`ifdef FLIT_CHECKSUM_EN
            id_q    <= FLIT_PAYLOAD;
            csum_q  <= csum_q ^ din;
            if (last_word) state_q <= S_CSUM;
`else
            if (last_word) begin
              id_q    <= FLIT_TAIL;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              id_q    <= FLIT_PAYLOAD;
            end
`endif
          end
        end
        default: begin
          // S_ZTAIL / S_CSUM: a standalone TAIL that consumes no payload word.
          if (slot_free) begin
            empty_q <= 1'b0;
            id_q    <= FLIT_TAIL;
            data_q  <= tail_data;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign empty     = empty_q;
  assign flit_id   = id_q;
  assign dst_addr  = dst_q;
  assign flit_data = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_flit_packetizer.sv
// Bench for flit_packetizer: directed scenarios plus randomized traffic against a flit-list reference model.
`timescale 1ns/1ps
module tb_flit_packetizer;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam logic [2:0] H = 3'b001;
  localparam logic [2:0] P = 3'b010;
  localparam logic [2:0] T = 3'b100;
`ifdef FLIT_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  typedef struct packed {
    logic [2:0]        id;
    logic [3:0]        dst;
    logic [DATA_W-1:0] data;
  } flit_t;

  logic              clk;
  logic              rst;
  logic [3:0]        cur_addr;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [3:0]        pkt_dst;
  logic [LEN_W-1:0]  pkt_len;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din;
  logic              rd;
  logic              empty;
  logic [2:0]        flit_id;
  logic [3:0]        dst_addr;
  logic [DATA_W-1:0] flit_data;
  logic              busy;

  flit_packetizer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cur_addr(cur_addr),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .rd(rd), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
    .flit_data(flit_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet store and payload words, in issue order.
  logic [3:0]        pk_dst [64];
  int                pk_len [64];
  int                pk_base[64];
  logic [DATA_W-1:0] wd     [2048];
  int npk = 0, pk_next = 0, nwd = 0, wd_next = 0;
  int src_fix = -1;
  int dr_seen = 0;
  flit_t exp_q[$];
  flit_t got_q[$];
  int    pop_cyc[$];
  bit    rd_pat[$];

  task automatic add_pkt(input logic [3:0] d, input int l, input bit fixed);
    pk_dst[npk]  = d;
    pk_len[npk]  = l;
    pk_base[npk] = nwd;
    for (int i = 0; i < l; i++) begin
      wd[nwd] = fixed ? DATA_W'((i + 1) * 'h11) : DATA_W'($urandom);
      nwd++;
    end
    npk++;
  endtask

  function automatic int n_flits(input int l);
    return (CSUM != 0) ? l + 2 : ((l > 0) ? l : 1) + 1;
  endfunction

  // Expected flit list of one packet, built straight from the packet rules.
  task automatic model_pkt(input int p, input logic [3:0] src);
    logic [DATA_W-1:0] hdr, x;
    int l, b;
    l   = pk_len[p];
    b   = pk_base[p];
    hdr = DATA_W'({LEN_W'(l), src, pk_dst[p]});
    exp_q.push_back('{id: H, dst: pk_dst[p], data: hdr});
    x = hdr;
    for (int i = 0; i < l; i++) begin
      x ^= wd[b + i];
      if (CSUM != 0 || i < l - 1) exp_q.push_back('{id: P, dst: pk_dst[p], data: wd[b + i]});
      else                        exp_q.push_back('{id: T, dst: pk_dst[p], data: wd[b + i]});
    end
    if (CSUM != 0)   exp_q.push_back('{id: T, dst: pk_dst[p], data: x});
    else if (l == 0) exp_q.push_back('{id: T, dst: pk_dst[p], data: '0});
  endtask

  function automatic int n_gaps();
    int g = 0;
    for (int i = 1; i < pop_cyc.size(); i++)
      if (pop_cyc[i] != pop_cyc[i-1] + 1) g++;
    return g;
  endfunction

  task automatic clear();
    got_q.delete();
    pop_cyc.delete();
    dr_seen = 0;
  endtask

  // Drives every pending descriptor and word; entered and left just after a rising edge.
  task automatic run(input string tag, input int rd_pct, input int dv_pct, input int max_cyc);
    int cyc;
    logic hold_v;
    logic [DATA_W+6:0] held;
    flit_t f;
    cyc = 0;
    hold_v = 1'b0;
    held = '0;
    while ((pk_next < npk || exp_q.size() > 0) && cyc < max_cyc) begin
      pkt_valid = (pk_next < npk);
      pkt_dst   = (pk_next < npk) ? pk_dst[pk_next] : 4'($urandom);
      pkt_len   = (pk_next < npk) ? LEN_W'(pk_len[pk_next]) : LEN_W'($urandom);
      cur_addr  = (src_fix >= 0) ? 4'(src_fix) : 4'($urandom);
      din_valid = (wd_next < nwd) && ($urandom_range(99) < dv_pct);
      din       = (wd_next < nwd) ? wd[wd_next] : DATA_W'($urandom);
      if (rd_pat.size() > 0) rd = rd_pat.pop_front();
      else                   rd = ($urandom_range(99) < rd_pct);
      @(negedge clk);
      if (hold_v) chk({tag, "_hold"}, {empty, flit_id, dst_addr, flit_data}, {1'b0, held});
      hold_v = !empty && !rd;
      if (hold_v) begin
        held = {flit_id, dst_addr, flit_data};
        chk({tag, "_hold_rdy"}, {pkt_ready, din_ready}, 2'b00);
      end
      if (din_ready) dr_seen++;
      if (pkt_valid && pkt_ready) begin
        model_pkt(pk_next, cur_addr);
        pk_next++;
      end
      if (din_valid && din_ready) wd_next++;
      if (!empty && rd) begin
        if (exp_q.size() == 0) chk({tag, "_extra_flit"}, exp_q.size(), 1);
        else begin
          f = exp_q.pop_front();
          chk({tag, "_flit"}, {flit_id, dst_addr, flit_data}, f);
        end
        got_q.push_back(flit_t'({flit_id, dst_addr, flit_data}));
        pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (pk_next < npk || exp_q.size() > 0) begin
      chk({tag, "_drain"}, exp_q.size() + npk - pk_next, 0);
      exp_q.delete();
      pk_next = npk;
      wd_next = nwd;
    end
    pkt_valid = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] t2_tail;
    int p, tot;
    rst = 1'b0; pkt_valid = 1'b1; pkt_dst = 4'h3; pkt_len = 4'd2; cur_addr = 4'h1;
    din_valid = 1'b0; din = '0; rd = 1'b0;

    // Reset held with a descriptor offered
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_flit_id", flit_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dst_data", {dst_addr, flit_data}, 0);
    pkt_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rel_pkt_ready", pkt_ready, 1);

    // Basic packet with continuous pop
    clear(); src_fix = 5;
    add_pkt(4'hA, 3, 1'b1);
    run("t2", 100, 100, 200);
    t2_tail = (CSUM != 0) ? DATA_W'('h35A ^ 'h11 ^ 'h22 ^ 'h33) : DATA_W'('h33);
    chk("t2_npop", got_q.size(), 4 + CSUM);
    chk("t2_hdr", {got_q[0].id, got_q[0].dst, got_q[0].data}, {H, 4'hA, DATA_W'('h35A)});
    chk("t2_tail", {got_q[got_q.size()-1].id, got_q[got_q.size()-1].data}, {T, t2_tail});
    chk("t2_hdr_cycle", pop_cyc[0], 1);
    chk("t2_gaps", n_gaps(), 0);
    chk("t2_drain_empty", empty, 1);

    // Downstream stall right after the HEADER
    clear();
    rd_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    add_pkt(4'hA, 3, 1'b1);
    run("t3", 100, 100, 200);
    chk("t3_npop", got_q.size(), 4 + CSUM);
    chk("t3_hdr_cycle", pop_cyc[0], 5);

    // Zero-length packet
    clear();
    add_pkt(4'h0, 0, 1'b0);
    run("t4", 100, 100, 100);
    chk("t4_npop", got_q.size(), 2);
    chk("t4_hdr", got_q[0].data, 'h050);
    chk("t4_tail", {got_q[1].id, got_q[1].data}, {T, (CSUM != 0) ? DATA_W'('h050) : DATA_W'(0)});
    chk("t4_din_ready", dr_seen, 0);

    // Back-to-back single-word packets, one with dst equal to own address
    clear();
    add_pkt(4'h5, 1, 1'b0);
    add_pkt(4'hC, 1, 1'b0);
    run("t5", 100, 100, 100);
    chk("t5_npop", got_q.size(), 2 * n_flits(1));
    chk("t5_gaps", n_gaps(), 0);
    chk("t5_ids", {got_q[0].id, got_q[1 + CSUM].id, got_q[2 + CSUM].id}, {H, T, H});

    // Reset in the middle of a len=5 packet
    src_fix = -1;
    add_pkt(4'h3, 5, 1'b0);
    p = npk - 1;
    pkt_valid = 1'b1; pkt_dst = 4'h3; pkt_len = 4'd5; cur_addr = 4'h6;
    rd = 1'b1; din_valid = 1'b1; din = wd[pk_base[p]];
    @(posedge clk); #1;
    pkt_valid = 1'b0; pk_next = npk;
    chk("t6_hdr", flit_id, H);
    @(posedge clk); #1;
    din = wd[pk_base[p] + 1];
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("t6_pay2", {flit_id, flit_data}, {P, wd[pk_base[p] + 1]});
    rst = 1'b0;
    #1;
    chk("t6_abort", {empty, busy, flit_id}, {1'b1, 1'b0, 3'b000});
    @(posedge clk); #1;
    rst = 1'b1;
    wd_next = pk_base[p] + 5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6_no_tail", {empty, busy}, 2'b10);
    end
    clear();
    add_pkt(4'h9, 1, 1'b0);
    run("t6b", 50, 50, 200);
    chk("t6b_npop", got_q.size(), n_flits(1));

    // Randomized traffic with random back-pressure and payload gaps
    clear(); tot = 0;
    add_pkt(4'($urandom), 15, 1'b0); tot += n_flits(15);
    for (int i = 0; i < 30; i++) begin
      int l;
      l = $urandom_range(0, 15);
      add_pkt(4'($urandom), l, 1'b0);
      tot += n_flits(l);
    end
    run("t7", 70, 70, 5000);
    chk("t7_npop", got_q.size(), tot);

    // Full-rate stream: no bubbles across packet boundaries
    clear(); tot = 0;
    for (int i = 0; i < 12; i++) begin
      int l;
      l = (i == 0) ? 15 : $urandom_range(0, 15);
      add_pkt(4'($urandom), l, 1'b0);
      tot += n_flits(l);
    end
    run("t8", 100, 100, 3000);
    chk("t8_npop", got_q.size(), tot);
    chk("t8_gaps", n_gaps(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
